// File: rtl/aram_pkg.sv
// rtl/aram_pkg.sv - shared owner/state types and request-vector indices for the ARAM arbiter
// Purpose : common definitions imported by aram_prio_sel and aram_arbiter.
// Contents: owner_e (bus owner code, also the OWNER output encoding),
//           state_e (transaction FSM), REQ_* bit positions in the request vector.
package aram_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_SMP  = 2'b01,
      OWN_DSP  = 2'b10,
      OWN_HOST = 2'b11
   } owner_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   localparam int REQ_SMP  = 0;
   localparam int REQ_DSP  = 1;
   localparam int REQ_HOST = 2;

endpackage

// File: rtl/aram_prio_sel.sv
// rtl/aram_prio_sel.sv - fixed-priority winner select with host starvation override
// Purpose : picks the next ARAM owner from the request vector.
// Ports   : req_i[2:0]  request vector indexed by REQ_SMP/REQ_DSP/REQ_HOST
//           starve_i    host has waited long enough to outrank the SMP
//           winner_o    owner code of the winner (OWN_NONE when no request)
module aram_prio_sel
   import aram_pkg::*;
(
   input  logic [2:0] req_i,
   input  logic       starve_i,
   output logic [1:0] winner_o
);

   // DSP always wins; a starved host only jumps ahead of the SMP.
   always_comb begin
      winner_o = OWN_NONE;
      if (req_i[REQ_DSP]) begin
         winner_o = OWN_DSP;
      end else if (req_i[REQ_HOST] && starve_i) begin
         winner_o = OWN_HOST;
      end else if (req_i[REQ_SMP]) begin
         winner_o = OWN_SMP;
      end else if (req_i[REQ_HOST]) begin
         winner_o = OWN_HOST;
      end
   end

endmodule

// File: rtl/aram_arbiter.sv
// rtl/aram_arbiter.sv - three-way arbiter sharing the single-port audio RAM
// Purpose : serialises SMP, DSP and host accesses onto the variable-latency
//           ARAM controller, one access in flight behind a req/ack handshake.
// Macro   : ARAM_HOST_PORT_EN - host port joins arbitration and starvation
//           guard is built; without it host inputs are ignored, HOST_ACK/HOST_DI read 0.
// Ports   : CLK, RST_N (async, active low)
//           SMP_/DSP_/HOST_ REQ, A, DO, WE_N in; DI, ACK out (ACK = 1-cycle pulse)
//           MEM_REQ, MEM_A, MEM_DO, MEM_WE_N out; MEM_DI, MEM_ACK in
//           BUSY (transaction in flight), OWNER (00 none, 01 SMP, 10 DSP, 11 host)
module aram_arbiter
   import aram_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int HOST_STARVE = 8
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              SMP_REQ,
   input  logic [ADDR_W-1:0] SMP_A,
   input  logic [7:0]        SMP_DO,
   input  logic              SMP_WE_N,
   output logic [7:0]        SMP_DI,
   output logic              SMP_ACK,
   input  logic              DSP_REQ,
   input  logic [ADDR_W-1:0] DSP_A,
   input  logic [7:0]        DSP_DO,
   input  logic              DSP_WE_N,
   output logic [7:0]        DSP_DI,
   output logic              DSP_ACK,
   input  logic              HOST_REQ,
   input  logic [ADDR_W-1:0] HOST_A,
   input  logic [7:0]        HOST_DO,
   input  logic              HOST_WE_N,
   output logic [7:0]        HOST_DI,
   output logic              HOST_ACK,
   output logic              MEM_REQ,
   output logic [ADDR_W-1:0] MEM_A,
   output logic [7:0]        MEM_DO,
   output logic              MEM_WE_N,
   input  logic [7:0]        MEM_DI,
   input  logic              MEM_ACK,
   output logic              BUSY,
   output logic [1:0]        OWNER
);

   localparam int CNT_W = $clog2(HOST_STARVE + 1);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [ADDR_W-1:0] a_q, a_d;
   logic [7:0]        do_q, do_d;
   logic              we_n_q, we_n_d;
   logic [7:0]        smp_di_q, smp_di_d;
   logic [7:0]        dsp_di_q, dsp_di_d;
   logic [2:0]        req_vec;
   logic              starve;
   logic [1:0]        winner_raw;
   owner_e            winner;

`ifdef ARAM_HOST_PORT_EN
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic [7:0]        host_di_q, host_di_d;

   assign req_vec = {HOST_REQ, DSP_REQ, SMP_REQ};
   assign starve  = (starve_q == CNT_W'(HOST_STARVE));
`else
   logic              unused_host;

   assign req_vec     = {1'b0, DSP_REQ, SMP_REQ};
   assign starve      = 1'b0;
   assign unused_host = ^{HOST_REQ, HOST_A, HOST_DO, HOST_WE_N, CNT_W'(HOST_STARVE)};
`endif

   aram_prio_sel u_prio (
      .req_i    (req_vec),
      .starve_i (starve),
      .winner_o (winner_raw)
   );

   assign winner = owner_e'(winner_raw);

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      a_d      = a_q;
      do_d     = do_q;
      we_n_d   = we_n_q;
      smp_di_d = smp_di_q;
      dsp_di_d = dsp_di_q;
`ifdef ARAM_HOST_PORT_EN
      host_di_d = host_di_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (winner != OWN_NONE) begin
               owner_d = winner;
               state_d = ST_ISSUE;
               case (winner)
                  OWN_DSP: begin
                     a_d = DSP_A; do_d = DSP_DO; we_n_d = DSP_WE_N;
                  end
`ifdef ARAM_HOST_PORT_EN
                  OWN_HOST: begin
                     a_d = HOST_A; do_d = HOST_DO; we_n_d = HOST_WE_N;
                  end
`endif
                  default: begin
                     a_d = SMP_A; do_d = SMP_DO; we_n_d = SMP_WE_N;
                  end
               endcase
            end
         end
         ST_ISSUE: begin
            if (MEM_ACK) begin
               state_d = ST_DONE;
               // Only reads touch a DI register, and only the owner's.
               if (we_n_q) begin
                  case (owner_q)
                     OWN_SMP:  smp_di_d = MEM_DI;
                     OWN_DSP:  dsp_di_d = MEM_DI;
`ifdef ARAM_HOST_PORT_EN
                     OWN_HOST: host_di_d = MEM_DI;
`endif
                     default: ;
                  endcase
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
         end
         default: begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         owner_q  <= OWN_NONE;
         a_q      <= '0;
         do_q     <= '0;
         we_n_q   <= 1'b1;
         smp_di_q <= '0;
         dsp_di_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         a_q      <= a_d;
         do_q     <= do_d;
         we_n_q   <= we_n_d;
         smp_di_q <= smp_di_d;
         dsp_di_q <= dsp_di_d;
      end
   end

`ifdef ARAM_HOST_PORT_EN
   // Counts non-host grants while the host waits; any host grant or a
   // withdrawn host request restarts the count.
   always_comb begin
      starve_d = starve_q;
      if (!HOST_REQ) begin
         starve_d = '0;
      end else if (state_q == ST_IDLE && winner == OWN_HOST) begin
         starve_d = '0;
      end else if (state_q == ST_IDLE && winner != OWN_NONE && !starve) begin
         starve_d = starve_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         starve_q  <= '0;
         host_di_q <= '0;
      end else begin
         starve_q  <= starve_d;
         host_di_q <= host_di_d;
      end
   end

   assign HOST_DI  = host_di_q;
   assign HOST_ACK = (state_q == ST_DONE) && (owner_q == OWN_HOST);
`else
   assign HOST_DI  = 8'h00;
   assign HOST_ACK = 1'b0;
`endif

   assign MEM_REQ  = (state_q == ST_ISSUE);
   assign MEM_A    = a_q;
   assign MEM_DO   = do_q;
   assign MEM_WE_N = we_n_q;
   assign SMP_DI   = smp_di_q;
   assign DSP_DI   = dsp_di_q;
   assign SMP_ACK  = (state_q == ST_DONE) && (owner_q == OWN_SMP);
   assign DSP_ACK  = (state_q == ST_DONE) && (owner_q == OWN_DSP);
   assign BUSY     = (state_q != ST_IDLE);
   assign OWNER    = owner_q;

endmodule

// File: doc/aram_arbiter.md
# aram_arbiter

Shares the single-port 64 KB audio RAM among the SPC700 (SMP), the S-DSP and a host loader/debug port. It sits between the SMP memory bus (`A`/`DI`/`DO`/`WE_N`) and the ARAM memory controller, which has variable latency. Fixed priority and a host starvation guard order the requests, and one access is in flight at a time behind a req/ack handshake.

## Interface
Parameters:
- `ADDR_W`, default 16: ARAM address width.
- `HOST_STARVE`, default 8: number of consecutive non-host grants, while `HOST_REQ` is high, after which the host outranks the SMP.

Ports (name, direction, width, meaning). Clock is `CLK`, reset is `RST_N`; one clock; reset is asynchronous and active-low.
- `CLK` in 1: clock.
- `RST_N` in 1: asynchronous active-low reset.
- `SMP_REQ` in 1 / `SMP_A` in ADDR_W / `SMP_DO` in 8 / `SMP_WE_N` in 1: SMP request, address, write data, write strobe (0 = write).
- `SMP_DI` out 8 / `SMP_ACK` out 1: SMP read data; one-cycle completion pulse.
- `DSP_REQ`, `DSP_A`, `DSP_DO`, `DSP_WE_N`, `DSP_DI`, `DSP_ACK`: same as the SMP group, for the DSP.
- `HOST_REQ`, `HOST_A`, `HOST_DO`, `HOST_WE_N`, `HOST_DI`, `HOST_ACK`: same as the SMP group, for the host.
- `MEM_REQ` out 1 / `MEM_A` out ADDR_W / `MEM_DO` out 8 / `MEM_WE_N` out 1: request to the memory controller.
- `MEM_DI` in 8 / `MEM_ACK` in 1: memory read data and completion.
- `BUSY` out 1: a transaction is in flight (state is not IDLE).
- `OWNER` out 2: current owner. 00 none, 01 SMP, 10 DSP, 11 HOST.

## Operation
- FSM states: IDLE, ISSUE, DONE.
- **IDLE:** samples the REQ inputs.
  - Winner order: DSP > SMP > HOST.
  - Exception: HOST beats SMP when `starve_cnt == HOST_STARVE`. HOST never beats DSP.
  - On a winner: latch A/DO/WE_N and OWNER, then go to ISSUE. Otherwise stay in IDLE.
- **ISSUE:** `MEM_REQ = 1` with `MEM_A`/`MEM_DO`/`MEM_WE_N` held stable from the latch.
  - On `MEM_ACK`: a read captures `MEM_DI` into the owner's DI register; then go to DONE.
- **DONE:** the owner's ACK is high for exactly this cycle, then go to IDLE. OWNER clears to 00 on entering IDLE.
- DI registers hold their last read value. Writes and other owners' accesses never change them.
- `starve_cnt`:
  - increments (saturating at `HOST_STARVE`) on each non-host grant while `HOST_REQ` = 1;
  - clears on a host grant or when `HOST_REQ` = 0.
- Requester rules:
  - hold REQ and the payload stable until ACK;
  - REQ still high in the cycle after ACK counts as a new request.
- A REQ dropped mid-transaction does not abort: the access completes and ACK still pulses.
- `MEM_ACK` is ignored while `MEM_REQ` = 0.
- Reset values:
  - `MEM_REQ` 0, `MEM_WE_N` 1, `MEM_A` 0, `MEM_DO` 0;
  - all ACKs 0, all DIs 0x00;
  - `OWNER` 00, `BUSY` 0, `starve_cnt` 0, state IDLE.
- Reset asserted mid-transaction abandons the access immediately. The memory controller tolerates a `MEM_REQ` withdrawal.

## Timing
- Arbitration decision is registered: REQ sampled in cycle 0 gives `MEM_REQ` high in cycle 1.
- `MEM_ACK` in cycle k (k ≥ 1) gives owner ACK and valid DI in cycle k+1, and IDLE in cycle k+2.
- Minimum REQ→ACK latency is 2 cycles.
- Maximum throughput is one access per 3 cycles.
- Simultaneous requests are served in priority order, one full transaction each. The next grant is decided in the IDLE cycle that follows DONE.
- All outputs are registered. No combinational path from any REQ or `MEM_ACK` to any output.

## Configuration
- `ARAM_HOST_PORT_EN` defined: the host port takes part in arbitration and `starve_cnt` is present.
- Undefined:
  - host inputs are ignored;
  - `HOST_ACK` and `HOST_DI` are tied 0;
  - the starve logic is removed;
  - OWNER never reads 11.

## Structure
- Package `aram_pkg`: owner enum (`OWN_NONE`, `OWN_SMP`, `OWN_DSP`, `OWN_HOST`), FSM state typedef, and owner encodings.
- One sub-module, `aram_prio_sel`: priority and starvation selection. It takes the REQ vector and starve flag and produces the winner owner code.
- All registers, the latch and the FSM live in `aram_arbiter`.

## Test plan
- **DSP/SMP collision:** `DSP_REQ` and `SMP_REQ` rise in cycle 0; `MEM_ACK` is returned in the first ISSUE cycle. Expect `DSP_ACK` in cycle 2 and `SMP_ACK` in cycle 5.
- **Delayed SMP read:** SMP reads 0x1234; memory returns `MEM_DI` = 0x5A with `MEM_ACK` in cycle 5. Expect `MEM_A` = 0x1234 stable in cycles 1–5, `SMP_ACK` in cycle 6 with `SMP_DI` = 0x5A, and `DSP_DI` unchanged.
- **DSP write:** DSP writes 0xA5 to 0xFFFF. Expect `MEM_WE_N` = 0, `MEM_DO` = 0xA5, `DSP_ACK` pulsed once, and `DSP_DI` unchanged.
- **Host starvation** (`HOST_STARVE` = 8, macro on): SMP and HOST both request continuously. Expect 8 SMP grants, then the 9th grant goes to the host, then SMP grants resume.
- **Reset mid-access:** assert `RST_N` low in ISSUE. Expect `MEM_REQ` = 0 and `OWNER` = 00 immediately, and no ACK pulses after release until a new REQ arrives.
- **Macro off:** `HOST_REQ` held high for 100 cycles. Expect `HOST_ACK` to stay 0 and `HOST_A` never to appear on `MEM_A`.
